// File: rtl/bp_gshare_ras.sv
// Gshare direction predictor with a direct-mapped BTB, a return-address stack and an ordered branch queue.
// Latency: the prediction is registered and appears one cycle after the lookup.
// Backpressure: if_ready drops while the OBQ is full, and cond lookups are then dropped; a mispredict discards the same-cycle lookup.
module bp_gshare_ras #(
    parameter int BH_SIZE   = 8,
    parameter int BTB_ROWS  = 32,
    parameter int TAG_SIZE  = 10,
    parameter int OBQ_DEPTH = 16,
    parameter int RAS_DEPTH = 8,
    localparam int IDX = $clog2(BTB_ROWS),
    localparam int QW  = $clog2(OBQ_DEPTH),
    localparam int RW  = $clog2(RAS_DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          if_valid,
    input  logic [31:0]   if_pc,
    input  logic          if_is_cond,
    input  logic          if_is_jump,
    input  logic          if_is_call,
    input  logic          if_is_ret,
    output logic          if_ready,
    output logic          pred_valid,
    output logic          pred_taken,
    output logic [31:0]   pred_target,
    output logic [QW-1:0] pred_tag,
    input  logic          rt_valid,
    input  logic          rt_is_cond,
    input  logic          rt_is_call,
    input  logic          rt_is_ret,
    input  logic          rt_taken,
    input  logic          rt_mispredict,
    input  logic [31:0]   rt_pc,
    input  logic [31:0]   rt_target,
    input  logic [QW-1:0] rt_tag
);
    localparam logic [QW-1:0] Q_ONE   = 1;
    localparam logic [QW:0]   Q_FULL  = (QW+1)'(OBQ_DEPTH);
    localparam logic [RW-1:0] R_ONE   = 1;
    localparam logic [RW:0]   RC_ONE  = 1;
    localparam logic [RW:0]   RC_FULL = (RW+1)'(RAS_DEPTH);

    logic [1:0]          pht     [2**BH_SIZE];
    logic                btb_vld [BTB_ROWS];
    logic [TAG_SIZE-1:0] btb_tag [BTB_ROWS];
    logic [31:0]         btb_tgt [BTB_ROWS];
    logic [BH_SIZE-1:0]  obq     [OBQ_DEPTH];
    logic [31:0]         ras     [RAS_DEPTH];

    logic [BH_SIZE-1:0]  ghr, arch_ghr, gidx, rt_ghr_nxt;
    logic [QW-1:0]       head, tail;
    logic [QW:0]         count;
    logic [RW-1:0]       ras_ptr, rt_ras_ptr, rt_ras_ptr_nxt;
    logic [RW:0]         ras_cnt, rt_ras_cnt, rt_ras_cnt_nxt;

    logic [IDX-1:0]      lk_idx, rt_idx;
    logic [TAG_SIZE-1:0] lk_tag, rt_btag;
    logic [31:0]         pc_plus4, lk_target;
    logic                btb_hit, lk_taken, flush, accept;
    logic                do_alloc, do_push, do_pop, rt_cond, rt_pop;
    logic [1:0]          pht_cur, pht_nxt;
    logic                unused_sigs;

    assign flush    = rt_valid & rt_mispredict;
    assign if_ready = (count != Q_FULL);
    assign gidx     = if_pc[BH_SIZE+1:2] ^ ghr;
    assign lk_idx   = if_pc[IDX+1:2];
    assign lk_tag   = if_pc[TAG_SIZE+IDX+1:IDX+2];
    assign rt_idx   = rt_pc[IDX+1:2];
    assign rt_btag  = rt_pc[TAG_SIZE+IDX+1:IDX+2];
    assign btb_hit  = btb_vld[lk_idx] && (btb_tag[lk_idx] == lk_tag);
    assign pc_plus4 = if_pc + 32'd4;

    assign accept   = if_valid & ~flush & ~(if_is_cond & ~if_ready);
    assign do_alloc = accept & if_is_cond;
    assign do_push  = accept & if_is_call;
    assign do_pop   = accept & if_is_ret & (ras_cnt != '0);
    assign rt_cond  = rt_valid & rt_is_cond;
    assign rt_pop   = rt_cond & (count != '0);

    assign unused_sigs = ^{rt_tag, rt_pc[31:TAG_SIZE+IDX+2], rt_pc[1:0]};

    always_comb begin
        lk_taken  = 1'b0;
        lk_target = pc_plus4;
        if (if_is_cond) begin
            lk_taken = pht[gidx][1] & btb_hit;
            if (lk_taken) lk_target = btb_tgt[lk_idx];
        end else if (if_is_jump || if_is_call) begin
            lk_taken = btb_hit;
            if (btb_hit) lk_target = btb_tgt[lk_idx];
        end else if (if_is_ret && ras_cnt != '0) begin
            lk_taken  = 1'b1;
            lk_target = ras[ras_ptr - R_ONE];
        end
    end

    // Architectural (retire-side) copies that a mispredict restores from
    always_comb begin
        rt_ghr_nxt     = rt_cond ? {arch_ghr[BH_SIZE-2:0], rt_taken} : arch_ghr;
        rt_ras_ptr_nxt = rt_ras_ptr;
        rt_ras_cnt_nxt = rt_ras_cnt;
        if (rt_valid && rt_is_call) begin
            rt_ras_ptr_nxt = rt_ras_ptr + R_ONE;
            if (rt_ras_cnt != RC_FULL) rt_ras_cnt_nxt = rt_ras_cnt + RC_ONE;
        end else if (rt_valid && rt_is_ret && rt_ras_cnt != '0) begin
            rt_ras_ptr_nxt = rt_ras_ptr - R_ONE;
            rt_ras_cnt_nxt = rt_ras_cnt - RC_ONE;
        end
    end

    always_comb begin
        pht_cur = pht[obq[head]];
        pht_nxt = pht_cur;
        if (rt_taken && pht_cur != 2'b11)       pht_nxt = pht_cur + 2'b01;
        else if (!rt_taken && pht_cur != 2'b00) pht_nxt = pht_cur - 2'b01;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2**BH_SIZE; i++) pht[i] <= 2'b01;
        end else if (rt_pop) begin
            pht[obq[head]] <= pht_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BTB_ROWS; i++) btb_vld[i] <= 1'b0;
        end else if (rt_valid && rt_taken && !rt_is_ret) begin
            btb_vld[rt_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (rt_valid && rt_taken && !rt_is_ret) begin
            btb_tag[rt_idx] <= rt_btag;
            btb_tgt[rt_idx] <= rt_target;
        end
        if (do_alloc) obq[tail]   <= gidx;
        if (do_push)  ras[ras_ptr] <= pc_plus4;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ghr         <= '0;
            arch_ghr    <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            ras_ptr     <= '0;
            ras_cnt     <= '0;
            rt_ras_ptr  <= '0;
            rt_ras_cnt  <= '0;
            pred_valid  <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= '0;
            pred_tag    <= '0;
        end else begin
            arch_ghr   <= rt_ghr_nxt;
            rt_ras_ptr <= rt_ras_ptr_nxt;
            rt_ras_cnt <= rt_ras_cnt_nxt;
            pred_valid <= accept;
            if (accept) begin
                pred_taken  <= lk_taken;
                pred_target <= lk_target;
                pred_tag    <= do_alloc ? tail : '0;
            end
            if (flush) begin
                ghr     <= rt_ghr_nxt;
                head    <= '0;
                tail    <= '0;
                count   <= '0;
                ras_ptr <= rt_ras_ptr_nxt;
                ras_cnt <= rt_ras_cnt_nxt;
            end else begin
                if (do_alloc) begin
                    ghr  <= {ghr[BH_SIZE-2:0], lk_taken};
                    tail <= tail + Q_ONE;
                end
                if (rt_pop) head <= head + Q_ONE;
                count <= count + (QW+1)'(do_alloc) - (QW+1)'(rt_pop);
                if (do_push) begin
                    ras_ptr <= ras_ptr + R_ONE;
                    if (ras_cnt != RC_FULL) ras_cnt <= ras_cnt + RC_ONE;
                end else if (do_pop) begin
                    ras_ptr <= ras_ptr - R_ONE;
                    ras_cnt <= ras_cnt - RC_ONE;
                end
            end
        end
    end
endmodule

// File: tb/tb_bp_gshare_ras.sv
// Directed bench for bp_gshare_ras: hand-computed predictions for lookup, training, OBQ full, RAS and mispredict repair.
module tb_bp_gshare_ras;
    logic        clock, reset;
    logic        if_valid, if_is_cond, if_is_jump, if_is_call, if_is_ret, if_ready;
    logic [31:0] if_pc;
    logic        pred_valid, pred_taken;
    logic [31:0] pred_target;
    logic [3:0]  pred_tag;
    logic        rt_valid, rt_is_cond, rt_is_call, rt_is_ret, rt_taken, rt_mispredict;
    logic [31:0] rt_pc, rt_target;
    logic [3:0]  rt_tag;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [3:0] C_COND = 4'b1000, C_JUMP = 4'b0100, C_CALL = 4'b0010, C_RET = 4'b0001, C_NONE = 4'b0000;
    localparam logic [2:0] R_COND = 3'b100, R_CALL = 3'b010;

    bp_gshare_ras dut (
        .clock(clock), .reset(reset),
        .if_valid(if_valid), .if_pc(if_pc),
        .if_is_cond(if_is_cond), .if_is_jump(if_is_jump), .if_is_call(if_is_call), .if_is_ret(if_is_ret),
        .if_ready(if_ready),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target), .pred_tag(pred_tag),
        .rt_valid(rt_valid), .rt_is_cond(rt_is_cond), .rt_is_call(rt_is_call), .rt_is_ret(rt_is_ret),
        .rt_taken(rt_taken), .rt_mispredict(rt_mispredict),
        .rt_pc(rt_pc), .rt_target(rt_target), .rt_tag(rt_tag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        if_valid = 0; if_pc = 0; {if_is_cond, if_is_jump, if_is_call, if_is_ret} = 4'b0;
        rt_valid = 0; {rt_is_cond, rt_is_call, rt_is_ret} = 3'b0;
        rt_taken = 0; rt_mispredict = 0; rt_pc = 0; rt_target = 0; rt_tag = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        clear_inputs();
    endtask

    task automatic set_lookup(input logic [31:0] pc, input logic [3:0] cls);
        if_valid = 1; if_pc = pc;
        {if_is_cond, if_is_jump, if_is_call, if_is_ret} = cls;
    endtask

    task automatic set_retire(input logic [2:0] cls, input logic taken, input logic misp,
                              input logic [31:0] pc, input logic [31:0] tgt, input logic [3:0] tag);
        rt_valid = 1; {rt_is_cond, rt_is_call, rt_is_ret} = cls;
        rt_taken = taken; rt_mispredict = misp; rt_pc = pc; rt_target = tgt; rt_tag = tag;
    endtask

    task automatic lookup(input logic [31:0] pc, input logic [3:0] cls);
        set_lookup(pc, cls);
        tick();
    endtask

    task automatic retire(input logic [2:0] cls, input logic taken, input logic [31:0] pc,
                          input logic [31:0] tgt, input logic [3:0] tag);
        set_retire(cls, taken, 1'b0, pc, tgt, tag);
        tick();
    endtask

    task automatic do_reset();
        reset = 0;
        @(posedge clock);
        #1;
        reset = 1;
    endtask

    task automatic chk_pred(input string tag, input logic taken, input logic [31:0] tgt);
        chk({tag, "_vld"}, {31'b0, pred_valid}, 32'd1);
        chk({tag, "_tkn"}, {31'b0, pred_taken}, {31'b0, taken});
        chk({tag, "_tgt"}, pred_target, tgt);
    endtask

    initial begin
        reset = 0;
        clear_inputs();
        repeat (2) @(posedge clock);
        #1;
        chk("rst_pred_valid", {31'b0, pred_valid}, 32'd0);
        chk("rst_pred_taken", {31'b0, pred_taken}, 32'd0);
        chk("rst_pred_target", pred_target, 32'd0);
        chk("rst_pred_tag", {28'b0, pred_tag}, 32'd0);
        chk("rst_if_ready", {31'b0, if_ready}, 32'd1);
        reset = 1;

        // Two untrained lookups of 0x100 (gidx 0x40), then train twice taken -> 0x200
        lookup(32'h100, C_COND);
        chk_pred("c0", 1'b0, 32'h104);
        chk("c0_tag", {28'b0, pred_tag}, 32'd0);
        lookup(32'h100, C_COND);
        chk("c1_tag", {28'b0, pred_tag}, 32'd1);
        retire(R_COND, 1'b1, 32'h100, 32'h200, 4'd0);
        chk("rt_no_pred", {31'b0, pred_valid}, 32'd0);
        retire(R_COND, 1'b1, 32'h100, 32'h200, 4'd1);
        lookup(32'h100, C_COND);
        chk_pred("c_trained", 1'b1, 32'h200);
        chk("c_trained_tag", {28'b0, pred_tag}, 32'd2);

        // Fill the OBQ, then probe full behaviour
        do_reset();
        for (int i = 0; i < 16; i++) lookup(32'h1000 + 32'(4 * i), C_COND);
        chk("full_last_tag", {28'b0, pred_tag}, 32'd15);
        chk("full_ready", {31'b0, if_ready}, 32'd0);
        lookup(32'h1040, C_COND);
        chk("full_drop_vld", {31'b0, pred_valid}, 32'd0);
        chk("full_still", {31'b0, if_ready}, 32'd0);
        set_lookup(32'h1044, C_COND);
        set_retire(R_COND, 1'b0, 1'b0, 32'h1000, 32'h0, 4'd0);
        tick();
        chk("full_rt_drop_vld", {31'b0, pred_valid}, 32'd0);
        chk("full_rt_ready", {31'b0, if_ready}, 32'd1);

        // BTB-hit call, returns, jumps, non-branch
        do_reset();
        retire(R_CALL, 1'b1, 32'h400, 32'h800, 4'd0);
        lookup(32'h400, C_CALL);
        chk_pred("call", 1'b1, 32'h800);
        chk("call_tag", {28'b0, pred_tag}, 32'd0);
        lookup(32'h900, C_RET);
        chk_pred("ret", 1'b1, 32'h404);
        lookup(32'h900, C_RET);
        chk_pred("ret_empty", 1'b0, 32'h904);
        lookup(32'h400, C_JUMP);
        chk_pred("jmp_hit", 1'b1, 32'h800);
        lookup(32'h500, C_JUMP);
        chk_pred("jmp_miss", 1'b0, 32'h504);
        lookup(32'h600, C_NONE);
        chk_pred("nonbr", 1'b0, 32'h604);

        // RAS overflow: nine calls, eight returns come back 9..2, ninth falls through
        do_reset();
        for (int i = 0; i < 9; i++) lookup(32'h2000 + 32'(16 * i), C_CALL);
        for (int k = 0; k < 8; k++) begin
            lookup(32'h3000, C_RET);
            chk_pred($sformatf("ras%0d", k), 1'b1, 32'h2004 + 32'(16 * (8 - k)));
        end
        lookup(32'h3000, C_RET);
        chk_pred("ras_under", 1'b0, 32'h3004);

        // Mispredict repair with a simultaneous lookup
        do_reset();
        lookup(32'h100, C_COND);
        lookup(32'h104, C_COND);
        lookup(32'h108, C_COND);
        chk("mp_pre_tag", {28'b0, pred_tag}, 32'd2);
        set_lookup(32'h10C, C_COND);
        set_retire(R_COND, 1'b1, 1'b1, 32'h100, 32'h200, 4'd0);
        tick();
        chk("mp_drop_vld", {31'b0, pred_valid}, 32'd0);
        chk("mp_ready", {31'b0, if_ready}, 32'd1);
        chk("mp_ghr", {24'b0, dut.ghr}, 32'd1);
        lookup(32'h110, C_COND);
        chk("mp_tag_restart", {28'b0, pred_tag}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
